fetch_stage: RTL and testbench

- Instruction-fetch stage of the RV32I 5-stage pipeline; directly upstream of the hazard-detection unit and the ID stage.
- Owns the PC and drives a pipelined instruction-memory request/grant/response interface.
- Buffers returned instructions in a small in-order fetch queue, and presents the IF pipeline register (instruction + PC + valid) to decode and hazard detection.
- Obeys the hazard unit's Stall and IF_ID_Flush, and redirects on taken branch/jump.

---
 rtl/fetch_stage.sv | 174 +++++++++++++++++
 tb/tb_fetch_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues pipelined IMEM requests,
// buffers in-order responses in a small queue and drives the IF register.
`timescale 1ns/1ps
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH  = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        Clk,
    input  logic        Reset_n,
    output logic        IMEM_req,
    output logic [31:0] IMEM_addr,
    input  logic        IMEM_gnt,
    input  logic        IMEM_rvalid,
    input  logic [31:0] IMEM_rdata,
    input  logic        Stall,
    input  logic        IF_ID_Flush,
    input  logic        Redirect,
    input  logic [31:0] Redirect_target,
    output logic [31:0] IF_Instruction,
    output logic [31:0] IF_PC,
    output logic        IF_Valid
);

    localparam int unsigned PW = $clog2(FQ_DEPTH);
    localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
    localparam logic [CW:0] DepthW = (CW + 1)'(FQ_DEPTH);

    logic [31:0]         pc_q, pc_d;
    logic [PW-1:0]       head_q, head_d, tail_q, tail_d, fill_q, fill_d;
    logic [CW-1:0]       count_q, count_d;       // allocated entries, filled or not
    logic [CW-1:0]       unfilled_q, unfilled_d; // allocated entries awaiting a response
    logic [CW-1:0]       discard_q, discard_d;   // old-path responses still to drop
    logic [31:0]         ent_pc_q    [FQ_DEPTH];
    logic [31:0]         ent_instr_q [FQ_DEPTH];
    logic [FQ_DEPTH-1:0] ent_filled_q;
    logic [31:0]         if_instr_q, if_pc_q;
    logic                if_valid_q;

    logic        handshake, fill_en, drop_en, pop_en;
    logic [CW:0] occupied, outstanding;
    logic        unused_tgt;

    assign unused_tgt  = ^Redirect_target[1:0];
    assign occupied    = {1'b0, count_q} + {1'b0, discard_q};
    assign outstanding = {1'b0, unfilled_q} + {1'b0, discard_q};

    // Request gating uses registered counts only, so req/addr stay stable until granted.
    assign IMEM_req  = Reset_n & ~Redirect & (occupied < DepthW);
    assign IMEM_addr = pc_q;
    assign handshake = IMEM_req & IMEM_gnt;

    // A response in the redirect cycle belongs to the old path and is never stored.
    assign fill_en = IMEM_rvalid & ~Redirect & (discard_q == '0) & (unfilled_q != '0);
    assign drop_en = IMEM_rvalid & ~Redirect & (discard_q != '0);
    assign pop_en  = ~Redirect & ~IF_ID_Flush & ~Stall & (count_q != '0) & ent_filled_q[head_q];

    assign IF_Instruction = if_instr_q;
    assign IF_PC          = if_pc_q;
    assign IF_Valid       = if_valid_q;

    // Next-state for PC, queue pointers and counters.
    always_comb begin
        pc_d       = pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        fill_d     = fill_q;
        count_d    = count_q;
        unfilled_d = unfilled_q;
        discard_d  = discard_q;
        if (Redirect) begin
            pc_d       = {Redirect_target[31:2], 2'b00};
            head_d     = '0;
            tail_d     = '0;
            fill_d     = '0;
            count_d    = '0;
            unfilled_d = '0;
            // Everything still outstanding must be dropped, minus the one arriving now.
            if (IMEM_rvalid && outstanding != '0) begin
                discard_d = CW'(outstanding - (CW + 1)'(1));
            end else begin
                discard_d = CW'(outstanding);
            end
        end else begin
            if (handshake) begin
                pc_d   = pc_q + 32'd4;
                tail_d = tail_q + PW'(1);
            end
            if (fill_en) begin
                fill_d = fill_q + PW'(1);
            end
            if (pop_en) begin
                head_d = head_q + PW'(1);
            end
            count_d    = count_q + CW'(handshake) - CW'(pop_en);
            unfilled_d = unfilled_q + CW'(handshake) - CW'(fill_en);
            discard_d  = discard_q - CW'(drop_en);
        end
    end

    // Control state registers.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            pc_q       <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            unfilled_q <= '0;
            discard_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fill_q     <= fill_d;
            count_q    <= count_d;
            unfilled_q <= unfilled_d;
            discard_q  <= discard_d;
        end
    end

    // Per-entry filled flags; a fill only becomes poppable on the following cycle.
    always_ff @(posedge Clk) begin
        if (!Reset_n || Redirect) begin
            ent_filled_q <= '0;
        end else begin
            if (handshake) begin
                ent_filled_q[tail_q] <= 1'b0;
            end
            if (fill_en) begin
                ent_filled_q[fill_q] <= 1'b1;
            end
        end
    end

    // Queue payload storage; validity is tracked by the flags and counters.
    always_ff @(posedge Clk) begin
        if (handshake) begin
            ent_pc_q[tail_q] <= pc_q;
        end
        if (fill_en) begin
            ent_instr_q[fill_q] <= IMEM_rdata;
        end
    end

    // IF pipeline register: redirect/flush bubble, stall hold, otherwise pop or bubble.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            if_valid_q <= 1'b0;
            if_instr_q <= NOP_INSTR;
            if_pc_q    <= 32'h0;
        end else if (Redirect || IF_ID_Flush) begin
            if_valid_q <= 1'b0;
            if_instr_q <= NOP_INSTR;
        end else if (Stall) begin
            if_valid_q <= if_valid_q;
        end else if (pop_en) begin
            if_valid_q <= 1'b1;
            if_instr_q <= ent_instr_q[head_q];
            if_pc_q    <= ent_pc_q[head_q];
        end else begin
            if_valid_q <= 1'b0;
            if_instr_q <= NOP_INSTR;
        end
    end

    // A response with nothing outstanding means the memory side is broken.
    always_ff @(posedge Clk) begin
        if (Reset_n && IMEM_rvalid) begin
            assert (discard_q != '0 || unfilled_q != '0);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural IMEM plus program-order model.
`timescale 1ns/1ps
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n, req, gnt, rvalid, stall, flush, redir, ifv;
    logic [31:0] addr, rdata, tgt, ifi, ifpc;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .FQ_DEPTH (4),
        .NOP_INSTR(NOP)
    ) dut (
        .Clk            (clk),
        .Reset_n        (rst_n),
        .IMEM_req       (req),
        .IMEM_addr      (addr),
        .IMEM_gnt       (gnt),
        .IMEM_rvalid    (rvalid),
        .IMEM_rdata     (rdata),
        .Stall          (stall),
        .IF_ID_Flush    (flush),
        .Redirect       (redir),
        .Redirect_target(tgt),
        .IF_Instruction (ifi),
        .IF_PC          (ifpc),
        .IF_Valid       (ifv)
    );

    int          errs = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int          nvalid = 0;
    logic [31:0] pend_addr[$];
    int unsigned pend_due[$];
    logic [31:0] fetch_pc, exp_pc, last_addr;
    logic        prev_wait, last_hs, last_req;
    bit          rsp_en, lat_rand;

    // Memory contents: any fixed function of the address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: respond, check request side, clock, check the IF register.
    task automatic cycle();
        logic [31:0] snap_i, snap_pc;
        logic        snap_v, hs;
        rvalid = 1'b0;
        rdata  = 32'h0;
        if (rst_n && rsp_en && pend_addr.size() > 0 && cyc >= pend_due[0]) begin
            rvalid = 1'b1;
            rdata  = imem(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        #1;
        snap_i  = ifi;
        snap_pc = ifpc;
        snap_v  = ifv;
        if (!rst_n || redir) chk("req_off", req, 0);
        if (rst_n && !redir && prev_wait) chk("req_hold", req, 1);
        if (rst_n && !redir && req) chk("fetch_addr", addr, fetch_pc);
        hs = req & gnt;
        if (hs) begin
            pend_addr.push_back(addr);
            pend_due.push_back(cyc + (lat_rand ? $urandom_range(1, 3) : 1));
            fetch_pc = fetch_pc + 32'd4;
        end
        prev_wait = rst_n & req & ~gnt;
        last_req  = req;
        last_addr = addr;
        last_hs   = hs;
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) begin
            chk("rst_valid", ifv, 0);
            chk("rst_instr", ifi, NOP);
            chk("rst_pc", ifpc, 0);
            fetch_pc  = RESET_PC;
            exp_pc    = RESET_PC;
            prev_wait = 1'b0;
            pend_addr.delete();
            pend_due.delete();
        end else if (redir) begin
            chk("redir_bubble_v", ifv, 0);
            chk("redir_bubble_i", ifi, NOP);
            fetch_pc = {tgt[31:2], 2'b00};
            exp_pc   = {tgt[31:2], 2'b00};
        end else if (flush) begin
            chk("flush_bubble_v", ifv, 0);
            chk("flush_bubble_i", ifi, NOP);
        end else if (stall) begin
            chk("stall_v", ifv, snap_v);
            chk("stall_i", ifi, snap_i);
            chk("stall_pc", ifpc, snap_pc);
        end else if (ifv) begin
            chk("deliver_pc", ifpc, exp_pc);
            chk("deliver_instr", ifi, imem(exp_pc));
            exp_pc = exp_pc + 32'd4;
            nvalid++;
        end else begin
            chk("bubble_instr", ifi, NOP);
        end
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!ifv && n < max);
        chk("wait_valid", ifv, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; gnt = 1'b1; rvalid = 1'b0; rdata = '0;
        stall = 1'b0; flush = 1'b0; redir = 1'b0; tgt = '0;
        rsp_en = 1'b1; lat_rand = 1'b0; prev_wait = 1'b0;
        fetch_pc = RESET_PC; exp_pc = RESET_PC;
        repeat (2) cycle();

        // Reset release: first grant, 2-cycle latency, then 1 instr/cycle.
        rst_n = 1'b1;
        cycle();
        chk("first_grant", last_hs, 1);
        chk("first_addr", last_addr, RESET_PC);
        cycle();
        chk("lat_bubble", ifv, 0);
        cycle();
        chk("lat_valid", ifv, 1);
        chk("lat_pc", ifpc, RESET_PC);
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("stream_valid", ifv, 1);
        end

        // Stall 3 cycles: queue fills and request drops, then no gap on release.
        stall = 1'b1;
        repeat (3) cycle();
        chk("full_req_drop", last_req, 0);
        stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("no_gap", ifv, 1);
        end

        // Redirect with two requests in flight.
        gnt = 1'b0;
        repeat (8) cycle();
        rsp_en = 1'b0;
        gnt = 1'b1;
        repeat (2) cycle();
        redir = 1'b1; tgt = 32'h0000_0100;
        cycle();
        redir = 1'b0; rsp_en = 1'b1;
        wait_valid(12);
        chk("redir_pc", ifpc, 32'h0000_0100);

        // Misaligned target is aligned down.
        redir = 1'b1; tgt = 32'h0000_0203;
        cycle();
        redir = 1'b0; gnt = 1'b0;
        cycle();
        chk("align_addr", last_addr, 32'h0000_0200);
        gnt = 1'b1;
        wait_valid(12);
        chk("align_pc", ifpc, 32'h0000_0200);

        // Redirect coinciding with an old-path response.
        repeat (4) cycle();
        redir = 1'b1; tgt = 32'h0000_0400;
        cycle();
        redir = 1'b0;
        wait_valid(12);
        chk("redir_rv_pc", ifpc, 32'h0000_0400);

        // Two flush cycles, then the head instruction still arrives.
        repeat (4) cycle();
        flush = 1'b1;
        repeat (2) cycle();
        flush = 1'b0;
        cycle();
        chk("flush_resume", ifv, 1);

        // Grant withheld 5 cycles: address parked at the model PC.
        repeat (2) cycle();
        gnt = 1'b0;
        repeat (5) cycle();
        chk("gnt_low_addr", last_addr, fetch_pc);
        chk("gnt_low_req", last_req, 1);
        gnt = 1'b1;
        cycle();
        chk("gnt_resume_hs", last_hs, 1);

        // PC wraps past the top of the address space.
        redir = 1'b1; tgt = 32'hFFFF_FFF8;
        cycle();
        redir = 1'b0;
        repeat (10) cycle();
        chk("wrap_pc_low", {31'b0, (ifpc < 32'h40)}, 1);

        // Reset mid-stream.
        repeat (3) cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("rst_first_hs", last_hs, 1);
        chk("rst_first_addr", last_addr, RESET_PC);

        // Randomized traffic against the program-order model.
        lat_rand = 1'b1;
        nvalid = 0;
        repeat (400) begin
            gnt    = ($urandom_range(0, 3) != 0);
            rsp_en = ($urandom_range(0, 4) != 0);
            stall  = ($urandom_range(0, 9) == 0);
            flush  = ($urandom_range(0, 19) == 0);
            redir  = ($urandom_range(0, 29) == 0);
            tgt    = $urandom;
            cycle();
        end
        gnt = 1'b1; rsp_en = 1'b1; stall = 1'b0; flush = 1'b0; redir = 1'b0;
        wait_valid(20);
        chk("rand_progress", {31'b0, (nvalid > 60)}, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
